// File: rtl/coffee_pkg.sv
// coffee_pkg: shared types and default timing for the coffee dispense sequencer.
//   state_e  - sequencer states (IDLE, GRIND, POUR, MILK, DONE)
//   recipe_e - drink latched on request (ESP, LONG, LATTE)
//   *_DEF    - default parameter values (time units / prescaler length)
package coffee_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRIND,
    POUR,
    MILK,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ESP,
    LONG,
    LATTE
  } recipe_e;

  localparam int TICK_DIV_DEF = 1000;
  localparam int CNT_W_DEF    = 8;
  localparam int GRIND_T_DEF  = 3;
  localparam int POUR_T_DEF   = 5;
  localparam int MILK_T_DEF   = 4;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: prescaler + unit counter timing one actuator phase.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - hold both counters at zero (asserted while no phase runs
//               and on the cycle a phase ends, so the next phase starts at 0)
//   len       - phase length in time units (1 .. 2^CNT_W-1)
//   expire    - one-cycle pulse on the tick that completes the phase
// A phase with len=T lasts exactly T*TICK_DIV cycles after clear drops.
module phase_timer #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // With TICK_DIV=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick   = (pre_q == PRE_W'(TICK_DIV - 1));
  assign expire = tick && ((cnt_q + CNT_W'(1)) == len);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coffee_dispense_seq.sv
// coffee_dispense_seq: timed actuator sequencer behind the drink selector.
// Rising edge on one of ef/eg/eh (espresso / long / latte) while idle starts
// grind -> pour (x2 for long) -> milk (latte only) -> one-cycle done.
//   clk, rst      - clock, synchronous active-high reset
//   ef, eg, eh    - one-hot stage levels from the selection FSM
//   grinder, water_valve, milk_valve - actuator enables (Moore)
//   busy          - high whenever not IDLE
//   done          - one-cycle pulse in the DONE state
//   err           - one-cycle pulse when several request edges arrive together
// Optional (macro COFFEE_ABORT_EN):
//   abort   - input, aborts a running phase back to IDLE without done
//   aborted - one-cycle pulse acknowledging the abort
module coffee_dispense_seq
  import coffee_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int GRIND_T  = GRIND_T_DEF,
  parameter int POUR_T   = POUR_T_DEF,
  parameter int MILK_T   = MILK_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ef,
  input  logic eg,
  input  logic eh,
  output logic grinder,
  output logic water_valve,
  output logic milk_valve,
  output logic busy,
  output logic done,
  output logic err
`ifdef COFFEE_ABORT_EN
  ,
  input  logic abort,
  output logic aborted
`endif
);

  state_e           state_q, state_d;
  recipe_e          recipe_q, recipe_d;
  logic             pass_q, pass_d;   // set after the first of two long pours
  logic [2:0]       prev_q;           // {ef,eg,eh} from last cycle
  logic             err_q, err_d;
  logic [2:0]       req;
  logic             timed;
  logic             expire;
  logic             clear;
  logic [CNT_W-1:0] len;

  // Edge registers follow the inputs in every state so a level held
  // through a sequence cannot look like a new request afterwards.
  assign req   = {ef, eg, eh} & ~prev_q;
  assign timed = (state_q == GRIND) || (state_q == POUR) || (state_q == MILK);

  // Counters restart whenever a phase ends (including the repeated long
  // pour) and are parked at zero outside timed phases.
  assign clear = !timed || expire;

  always_comb begin
    len = CNT_W'(GRIND_T);
    case (state_q)
      POUR:    len = CNT_W'(POUR_T);
      MILK:    len = CNT_W'(MILK_T);
      default: len = CNT_W'(GRIND_T);
    endcase
  end

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .len    (len),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    recipe_d = recipe_q;
    pass_d   = pass_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if ($onehot(req)) begin
          state_d  = GRIND;
          pass_d   = 1'b0;
          recipe_d = req[2] ? ESP : (req[1] ? LONG : LATTE);
        end else if (req != 3'b000) begin
          err_d = 1'b1;
        end
      end
      GRIND: if (expire) state_d = POUR;
      POUR: begin
        if (expire) begin
          case (recipe_q)
            LONG: begin
              if (!pass_q) pass_d  = 1'b1;   // second pour, valve stays open
              else         state_d = DONE;
            end
            LATTE:   state_d = MILK;
            default: state_d = DONE;
          endcase
        end
      end
      MILK:    if (expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef COFFEE_ABORT_EN
    if (abort && timed) state_d = IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      recipe_q <= ESP;
      pass_q   <= 1'b0;
      prev_q   <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      recipe_q <= recipe_d;
      pass_q   <= pass_d;
      prev_q   <= {ef, eg, eh};
      err_q    <= err_d;
    end
  end

  assign grinder     = (state_q == GRIND);
  assign water_valve = (state_q == POUR);
  assign milk_valve  = (state_q == MILK);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;

`ifdef COFFEE_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort && timed;
  end

  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_coffee_dispense_seq.sv
// Bench for coffee_dispense_seq: drinks are described by their phase
// durations; the expected output timeline is derived from those durations.
module tb_coffee_dispense_seq;

  localparam int TD = 2, GT = 3, PT = 5, MT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sel  = 3'b000;  // {ef,eg,eh}
  logic [2:0] sel1 = 3'b000;
  logic grinder, water_valve, milk_valve, busy, done, err;
  logic g1, w1, m1, b1, d1, e1;
`ifdef COFFEE_ABORT_EN
  logic abort = 1'b0;
  logic abort1 = 1'b0;
  logic aborted, aborted1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coffee_dispense_seq #(
    .TICK_DIV(TD), .CNT_W(8), .GRIND_T(GT), .POUR_T(PT), .MILK_T(MT)
  ) dut (
    .clk(clk), .rst(rst), .ef(sel[2]), .eg(sel[1]), .eh(sel[0]),
    .grinder(grinder), .water_valve(water_valve), .milk_valve(milk_valve),
    .busy(busy), .done(done), .err(err)
`ifdef COFFEE_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  coffee_dispense_seq #(
    .TICK_DIV(1), .CNT_W(8), .GRIND_T(1), .POUR_T(2), .MILK_T(1)
  ) dut1 (
    .clk(clk), .rst(rst), .ef(sel1[2]), .eg(sel1[1]), .eh(sel1[0]),
    .grinder(g1), .water_valve(w1), .milk_valve(m1),
    .busy(b1), .done(d1), .err(e1)
`ifdef COFFEE_ABORT_EN
    , .abort(abort1), .aborted(aborted1)
`endif
  );

  logic [5:0] obs;
  assign obs = {err, busy, done, milk_valve, water_valve, grinder};

  // per-output statistics over a capture window (index 0 = first negedge)
  int cnt[6], first[6], last[6];
  int overlap;

  task automatic capture(input int ncyc, input int drop_at, input int pulse_at,
                         input logic [2:0] pmask);
    for (int k = 0; k < 6; k++) begin cnt[k] = 0; first[k] = -1; last[k] = -1; end
    overlap = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++)
        if (obs[k]) begin
          if (cnt[k] == 0) first[k] = i;
          last[k] = i;
          cnt[k]++;
        end
      if ($countones(obs[2:0]) > 1) overlap++;
      if (i == drop_at) sel = 3'b000;
      if (i == pulse_at) sel = sel | pmask;
      if (i == pulse_at + 1) sel = sel & ~pmask;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000", obs);
    end
    checks++;
    if ({g1, w1, m1, b1, d1, e1} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs_td1: got %b want 000000", {g1, w1, m1, b1, d1, e1});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // three fixed drinks with held levels, then randomized drinks with random
  // hold lengths and stray request pulses while busy
  task automatic test_drinks();
    int rcp, hold, pls, g, w, m, tot;
    logic [2:0] own;
    for (int n = 0; n < 9; n++) begin
      rcp  = (n < 3) ? n : int'($urandom_range(0, 2));
      hold = (n < 3) ? 1000 : int'($urandom_range(0, 40));
      pls  = (n < 3) ? -5 : int'($urandom_range(2, 12));
      g    = GT * TD;
      w    = ((rcp == 1) ? 2 : 1) * PT * TD;
      m    = (rcp == 2) ? MT * TD : 0;
      tot  = g + w + m;
      own  = 3'b100 >> rcp;
      @(negedge clk);
      sel = own;
      capture(tot + 8, hold, pls, ~own);
      checks++;
      if (cnt[0] !== g || first[0] !== 0 || last[0] !== g - 1) begin
        errors++;
        $display("FAIL drink%0d grinder cnt/first/last: got %0d/%0d/%0d want %0d/0/%0d",
                 n, cnt[0], first[0], last[0], g, g - 1);
      end
      checks++;
      if (cnt[1] !== w || first[1] !== g || last[1] !== g + w - 1) begin
        errors++;
        $display("FAIL drink%0d water cnt/first/last: got %0d/%0d/%0d want %0d/%0d/%0d",
                 n, cnt[1], first[1], last[1], w, g, g + w - 1);
      end
      checks++;
      if (cnt[2] !== m || first[2] !== ((m > 0) ? g + w : -1)) begin
        errors++;
        $display("FAIL drink%0d milk cnt/first: got %0d/%0d want %0d/%0d",
                 n, cnt[2], first[2], m, (m > 0) ? g + w : -1);
      end
      checks++;
      if (cnt[3] !== 1 || first[3] !== tot) begin
        errors++;
        $display("FAIL drink%0d done cnt/at: got %0d/%0d want 1/%0d", n, cnt[3], first[3], tot);
      end
      checks++;
      if (cnt[4] !== tot + 1 || first[4] !== 0) begin
        errors++;
        $display("FAIL drink%0d busy cnt/first: got %0d/%0d want %0d/0", n, cnt[4], first[4], tot + 1);
      end
      checks++;
      if (cnt[5] !== 0 || overlap !== 0) begin
        errors++;
        $display("FAIL drink%0d err/overlap: got %0d/%0d want 0/0", n, cnt[5], overlap);
      end
      sel = 3'b000;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_multi_hot();
    @(negedge clk);
    sel = 3'b101;
    capture(6, 0, -5, 3'b000);
    checks++;
    if (cnt[5] !== 1 || first[5] !== 0) begin
      errors++; $display("FAIL multi_hot err cnt/at: got %0d/%0d want 1/0", cnt[5], first[5]);
    end
    checks++;
    if (cnt[4] !== 0 || cnt[0] !== 0 || cnt[1] !== 0 || cnt[2] !== 0 || cnt[3] !== 0) begin
      errors++;
      $display("FAIL multi_hot quiet: got busy=%0d g=%0d w=%0d m=%0d d=%0d want all 0",
               cnt[4], cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int dn;
    @(negedge clk);
    sel = 3'b001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        checks++;
        if (water_valve !== 1'b1) begin
          errors++; $display("FAIL mid_reset pour_before: got %b want 1", water_valve);
        end
        rst = 1'b1;
        sel = 3'b000;
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++; $display("FAIL mid_reset outputs: got %b want 000000", obs);
    end
    rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL mid_reset no_done: got %0d active cycles want 0", dn);
    end
    @(negedge clk);
    sel = 3'b100;
    capture(25, 1000, -5, 3'b000);
    checks++;
    if (cnt[0] !== 6 || cnt[1] !== 10 || cnt[2] !== 0 || cnt[3] !== 1 || first[3] !== 16) begin
      errors++;
      $display("FAIL mid_reset espresso g/w/m/d/d_at: got %0d/%0d/%0d/%0d/%0d want 6/10/0/1/16",
               cnt[0], cnt[1], cnt[2], cnt[3], first[3]);
    end
    sel = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // TICK_DIV=1, GRIND_T=1, POUR_T=2, MILK_T=1 latte
  task automatic test_tick1();
    int gc, wc, mc, dc, gat, dat;
    gc = 0; wc = 0; mc = 0; dc = 0; gat = -1; dat = -1;
    @(negedge clk);
    sel1 = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g1) begin gc++; if (gat < 0) gat = i; end
      if (w1) wc++;
      if (m1) mc++;
      if (d1) begin dc++; dat = i; end
      sel1 = 3'b000;
    end
    checks++;
    if (gc !== 1 || gat !== 0) begin
      errors++; $display("FAIL tick1 grinder cnt/at: got %0d/%0d want 1/0", gc, gat);
    end
    checks++;
    if (wc !== 2 || mc !== 1 || dc !== 1 || dat !== 4) begin
      errors++;
      $display("FAIL tick1 w/m/d/d_at: got %0d/%0d/%0d/%0d want 2/1/1/4", wc, mc, dc, dat);
    end
  endtask

`ifdef COFFEE_ABORT_EN
  task automatic test_abort();
    int dn;
    @(negedge clk);
    sel = 3'b001;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      sel = 3'b000;
      if (i == 17) begin
        checks++;
        if (milk_valve !== 1'b1) begin
          errors++; $display("FAIL abort milk_before: got %b want 1", milk_valve);
        end
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (milk_valve !== 1'b0 || aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort response milk/aborted/busy/done: got %b%b%b%b want 0100",
               milk_valve, aborted, busy, done);
    end
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || aborted || busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL abort after: got %0d active cycles want 0", dn);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_drinks();
    test_multi_hot();
    test_mid_reset();
    test_tick1();
`ifdef COFFEE_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
